// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline constants and the window tap-index helper.
// Frame geometry defaults here must match the line-buffer depth upstream.
package pixel_pkg;

   localparam int unsigned DATA_W     = 8;
   localparam int unsigned LINE_W     = 64;
   localparam int unsigned NUM_LINES  = 64;
   localparam int unsigned WIN_TAPS   = 9;
   localparam int unsigned CENTER_TAP = 4;
   localparam int unsigned CNT_W      = 6;

   typedef logic [CNT_W-1:0] pos_t;

   function automatic int unsigned tap(input int unsigned r, input int unsigned c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/window_shift_row.sv
// Three-tap pixel shift register; tap 0 holds the oldest pixel, tap 2 the newest.
module window_shift_row #(
   parameter int unsigned DATA_W = pixel_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [DATA_W-1:0]   din,
   output logic [3*DATA_W-1:0] taps
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taps <= '0;
      end else if (en) begin
         taps <= {din, taps[3*DATA_W-1:DATA_W]};
      end
   end

endmodule

// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster stream fed by two line buffers; emits a registered
// window with a valid pulse whenever all nine taps lie inside the frame.
module window_3x3
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_W    = pixel_pkg::DATA_W,
   parameter int unsigned LINE_W    = pixel_pkg::LINE_W,
   parameter int unsigned NUM_LINES = pixel_pkg::NUM_LINES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       sof,
   input  logic [DATA_W-1:0]          pix_in,
   input  logic [DATA_W-1:0]          line1_in,
   input  logic [DATA_W-1:0]          line2_in,
   output logic [WIN_TAPS*DATA_W-1:0] win_out,
   output logic                       win_valid,
   output logic [CNT_W-1:0]           row_idx,
   output logic [CNT_W-1:0]           col_idx,
   output logic                       eof
);

   if (LINE_W < 3 || LINE_W > 64) begin : g_bad_line_w
      $error("window_3x3: LINE_W must be in 3..64");
   end
   if (NUM_LINES < 3 || NUM_LINES > 64) begin : g_bad_num_lines
      $error("window_3x3: NUM_LINES must be in 3..64");
   end

   localparam pos_t ColLast = pos_t'(LINE_W - 1);
   localparam pos_t RowLast = pos_t'(NUM_LINES - 1);
   localparam pos_t PosOne  = pos_t'(1);
   localparam pos_t PosTwo  = pos_t'(2);

   pos_t col_q, row_q, col_d, row_d;
   pos_t cur_col, cur_row;
   logic in_frame, frame_end;

   logic [3*DATA_W-1:0] row_taps [3];

   window_shift_row #(.DATA_W(DATA_W)) u_row_top (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .din  (line2_in),
      .taps (row_taps[0])
   );

   window_shift_row #(.DATA_W(DATA_W)) u_row_mid (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .din  (line1_in),
      .taps (row_taps[1])
   );

   window_shift_row #(.DATA_W(DATA_W)) u_row_bot (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .din  (pix_in),
      .taps (row_taps[2])
   );

   // The shift rows are already registered, so the window is read straight from them.
   for (genvar r = 0; r < 3; r++) begin : g_win_row
      for (genvar c = 0; c < 3; c++) begin : g_win_col
         assign win_out[DATA_W*tap(r, c) +: DATA_W] = row_taps[r][DATA_W*c +: DATA_W];
      end
   end

   // sof overrides whatever the counters hold, including a coincident wrap.
   always_comb begin
      cur_col   = sof ? '0 : col_q;
      cur_row   = sof ? '0 : row_q;
      col_d     = col_q;
      row_d     = row_q;
      in_frame  = (cur_row >= PosTwo) && (cur_col >= PosTwo);
      frame_end = (cur_row == RowLast) && (cur_col == ColLast);
      if (en) begin
         if (cur_col == ColLast) begin
            col_d = '0;
            row_d = (cur_row == RowLast) ? '0 : cur_row + PosOne;
         end else begin
            col_d = cur_col + PosOne;
            row_d = cur_row;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_valid <= 1'b0;
         eof       <= 1'b0;
         row_idx   <= '0;
         col_idx   <= '0;
      end else begin
         win_valid <= 1'b0;
         eof       <= 1'b0;
         if (en) begin
            win_valid <= in_frame;
            eof       <= frame_end;
            row_idx   <= cur_row - PosOne;
            col_idx   <= cur_col - PosOne;
         end
      end
   end

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3: a raster-position model built on a linear pixel count
// is compared every cycle, with literal expectations for the landmark windows.
module tb_window_3x3;

   localparam int LW = 64;
   localparam int NL = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        sof = 1'b0;
   logic [7:0]  pix = '0;
   logic [7:0]  l1 = '0;
   logic [7:0]  l2 = '0;
   logic [71:0] win_out;
   logic        win_valid;
   logic [5:0]  row_idx;
   logic [5:0]  col_idx;
   logic        eof;

   window_3x3 #(.DATA_W(8), .LINE_W(LW), .NUM_LINES(NL)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sof       (sof),
      .pix_in    (pix),
      .line1_in  (l1),
      .line2_in  (l2),
      .win_out   (win_out),
      .win_valid (win_valid),
      .row_idx   (row_idx),
      .col_idx   (col_idx),
      .eof       (eof)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: linear pixel number within the frame plus 3-deep history per input.
   int          m_n = 0;
   logic [7:0]  hist [3][3];
   logic        e_valid = 0, e_eof = 0, m_last_en = 0;
   logic [5:0]  e_row = 0, e_col = 0;
   logic [71:0] e_win = '0;

   // Observations used by the directed literal checks.
   int          pulse_cnt, acc_cnt, bad_pos, first_acc;
   bit          first_seen, eof_seen;
   logic [5:0]  first_row, first_col, eof_row, eof_col;
   logic [71:0] first_win, wrap_win;

   localparam logic [71:0] FirstWin = 72'h02_01_00_42_41_40_82_81_80;

   task automatic arm();
      pulse_cnt = 0; acc_cnt = 0; bad_pos = 0; first_acc = -1;
      first_seen = 0; eof_seen = 0;
      first_row = '0; first_col = '0; eof_row = '0; eof_col = '0;
      first_win = '0; wrap_win = '0;
   endtask

   initial begin
      arm();
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_n = 0; e_valid = 0; e_eof = 0; e_row = 0; e_col = 0; e_win = '0; m_last_en = 0;
            for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) hist[r][c] = '0;
            chk("reset_win", win_out, 72'h0);
            chk("reset_valid", {71'h0, win_valid}, 72'h0);
            chk("reset_eof", {71'h0, eof}, 72'h0);
         end else begin
            chk("win_valid", {71'h0, win_valid}, {71'h0, e_valid});
            chk("eof", {71'h0, eof}, {71'h0, e_eof});
            chk("valid_after_idle", {71'h0, win_valid && !m_last_en}, 72'h0);
            if (e_valid) begin
               chk("win_out", win_out, e_win);
               chk("row_idx", {66'h0, row_idx}, {66'h0, e_row});
               chk("col_idx", {66'h0, col_idx}, {66'h0, e_col});
            end
            if (win_valid) begin
               pulse_cnt++;
               if (col_idx == 6'd63 || col_idx == 6'd0 || row_idx == 6'd63 || row_idx == 6'd0)
                  bad_pos++;
               if (!first_seen) begin
                  first_seen = 1; first_acc = acc_cnt;
                  first_row = row_idx; first_col = col_idx; first_win = win_out;
               end
               if (row_idx == 6'd2 && col_idx == 6'd1) wrap_win = win_out;
            end
            if (eof) begin
               eof_seen = 1; eof_row = row_idx; eof_col = col_idx;
            end
            // Advance the model with the inputs the next rising edge will accept.
            m_last_en = en;
            e_valid = 0;
            e_eof = 0;
            if (en) begin
               int r, c;
               acc_cnt++;
               if (sof) m_n = 0;
               r = m_n / LW;
               c = m_n % LW;
               for (int k = 0; k < 3; k++) begin
                  hist[k][0] = hist[k][1];
                  hist[k][1] = hist[k][2];
               end
               hist[0][2] = l2;
               hist[1][2] = l1;
               hist[2][2] = pix;
               for (int k = 0; k < 3; k++)
                  for (int j = 0; j < 3; j++) e_win[8*(3*k+j) +: 8] = hist[k][j];
               e_valid = (r >= 2) && (c >= 2);
               e_eof = (r == NL - 1) && (c == LW - 1);
               e_row = 6'(r - 1);
               e_col = 6'(c - 1);
               m_n = (m_n + 1) % (LW * NL);
            end
         end
      end
   end

   task automatic drive(input int c, input bit s);
      @(posedge clk);
      #1;
      en = 1'b1; sof = s;
      pix = 8'(c); l1 = 8'(c + 64); l2 = 8'(c + 128);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         en = 1'b0; sof = 1'b0;
      end
   endtask

   task automatic run_frame(input bit stalls);
      for (int n = 0; n < LW * NL; n++) begin
         if (stalls && $urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
         drive(n % LW, n == 0);
      end
      idle(2);
   endtask

   task automatic check_first(input string tag);
      chk({tag, "_first_latency"}, 72'(first_acc), 72'd131);
      chk({tag, "_first_row"}, {66'h0, first_row}, 72'd1);
      chk({tag, "_first_col"}, {66'h0, first_col}, 72'd1);
      chk({tag, "_first_win"}, first_win, FirstWin);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("init_row_idx", {66'h0, row_idx}, 72'd0);
      chk("init_col_idx", {66'h0, col_idx}, 72'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle(2);

      // Full frame, continuous enable.
      arm();
      run_frame(0);
      chk("frame_pulses", 72'(pulse_cnt), 72'd3844);
      check_first("frame");
      chk("wrap_win", wrap_win, FirstWin);
      chk("wrap_bad_pos", 72'(bad_pos), 72'd0);
      chk("eof_seen", {71'h0, eof_seen}, 72'd1);
      chk("eof_row", {66'h0, eof_row}, 72'd62);
      chk("eof_col", {66'h0, eof_col}, 72'd62);

      // Pixel after the frame end is (0,0): no pulse.
      arm();
      drive(0, 0);
      idle(2);
      chk("post_eof_pulses", 72'(pulse_cnt), 72'd0);

      // Same frame with random enable gaps.
      arm();
      run_frame(1);
      chk("stall_pulses", 72'(pulse_cnt), 72'd3844);
      check_first("stall");
      chk("stall_eof_row", {66'h0, eof_row}, 72'd62);

      // Mid-frame sof at (10,20).
      for (int n = 0; n < 10 * LW + 20; n++) drive(n % LW, n == 0);
      idle(2);
      arm();
      for (int k = 0; k < 2 * LW + 10; k++) drive(k % LW, k == 0);
      idle(2);
      check_first("midsof");

      // Reset held for three cycles mid-stream.
      for (int k = 0; k < 40; k++) drive(k % LW, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_row_idx", {66'h0, row_idx}, 72'd0);
         chk("midrst_col_idx", {66'h0, col_idx}, 72'd0);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      en = 1'b0;
      arm();
      for (int k = 0; k < 2 * LW + 10; k++) drive(k % LW, 0);
      idle(2);
      check_first("rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/window_3x3.md
# window_3x3

Downstream stage of the 64-deep line buffers in the pixel pipeline. It takes the current-row pixel and the two line-delayed pixels that the buffers produce, and shifts them through three 3-tap shift rows. It tracks the raster position and emits a registered 3×3 pixel window with a valid pulse whenever the window lies fully inside the frame. Its output feeds the convolution/filter stages.

## Interface
- `DATA_W`, default 8: pixel width.
- `LINE_W`, default 64: pixels per line; must equal the line-buffer depth.
- `NUM_LINES`, default 64: lines per frame.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: pixel accept; one pixel per cycle when high.
- `sof` in 1: start of frame; qualified by `en`; marks the accepted pixel as position (0,0).
- `pix_in` in DATA_W: current-row pixel (newest line).
- `line1_in` in DATA_W: pixel one line above, aligned with `pix_in`.
- `line2_in` in DATA_W: pixel two lines above, aligned with `pix_in`.
- `win_out` out 9*DATA_W: window; tap (r,c) occupies `[DATA_W*(3r+c) +: DATA_W]`, r=0 top (`line2_in`), c=0 oldest/leftmost; centre is tap 4.
- `win_valid` out 1: one-cycle pulse; `win_out` is a complete in-frame window.
- `row_idx` out 6: row of window centre.
- `col_idx` out 6: column of window centre.
- `eof` out 1: pulse coincident with the window for the last pixel of the frame.

## Operation
- Position counters `col`/`row` give the position of the pixel being accepted.
- On `en`: each shift row moves c0←c1, c1←c2, c2←new input.
- `col` increments and wraps LINE_W-1→0; on that wrap `row` increments and wraps NUM_LINES-1→0.
- `sof` with `en`: the accepted pixel is taken as (0,0); next `col`=1, `row`=0, regardless of prior counter state.
- `sof` without `en` is ignored.
- Window qualification, for an accepted pixel at (row,col):
  - `win_valid` next cycle iff row≥2 and col≥2.
  - `row_idx`=row-1, `col_idx`=col-1.
- Shift rows are not flushed at line boundaries. Stale columns are never emitted, because qualification requires col≥2.
- `eof` is asserted with `win_valid` for pixel (NUM_LINES-1, LINE_W-1).
- `en` low: all state holds; `win_valid` and `eof` are 0 that cycle; `win_out`, `row_idx`, `col_idx` hold their last values.
- Reset (any time, including mid-frame): shift rows, counters, and all outputs go to 0. The first accepted pixel after reset is (0,0) even without `sof`.

## Timing
- Latency: 1 cycle from the accepting edge to `win_out`/`win_valid`. Outputs are registered, with no combinational input→output path.
- Throughput: one window per accepted pixel after warm-up, with no bubbles.
- Upstream contract:
  - `line1_in` and `line2_in` are valid in the same cycle as `pix_in`.
  - `en` must match the `en` driving the line buffers.
- Simultaneous `sof` and wrap: `sof` wins.
- Counter arithmetic is 6-bit unsigned. LINE_W and NUM_LINES ≤ 64 and ≥ 3, checked at elaboration.

## Structure
- Shared package `pixel_pkg`:
  - DATA_W, LINE_W, NUM_LINES.
  - WIN_TAPS = 9, CENTER_TAP = 4.
  - Tap-index helper `tap(r,c) = 3r+c`.
- Sub-module `window_shift_row`: a 3-tap DATA_W shift register with enable and async active-low reset. It is instantiated three times (top, middle, bottom).
- Counters, qualification, and output registers live in the top module.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles mid-stream → all outputs 0. After release, the first `en` pixel is (0,0).
- **Full frame:**
  - Stimulus: `pix_in`=col, `line1_in`=col+64, `line2_in`=col+128, continuous `en`, `sof` on the first pixel.
  - First `win_valid` is 1 cycle after the 131st pixel, with `row_idx`=1, `col_idx`=1.
  - That window's taps are 128,129,130 / 64,65,66 / 0,1,2.
  - Exactly 62×62 = 3844 pulses per frame.
- **Line wrap:** pixels at col 0 and col 1 of row ≥2 produce no `win_valid`. The pixel at col 2 produces a window containing only current-line columns 0–2.
- **Stalls:** random `en` gaps of 1–5 cycles → window sequence and values identical to the full-frame run, and `win_valid` never high in a cycle after `en`=0.
- **Mid-frame `sof`:** assert `sof` at (10,20) → counters restart at (0,0), and no `win_valid` until new (2,2).
- **Frame end:** pixel (63,63) → `win_valid`=1, `eof`=1, `row_idx`=62, `col_idx`=62. The next pixel is (0,0), with no wrap glitch.
